// File: rtl/mul_result_unit.sv
// mul_result_unit: iterative shift-add multiplier with an integrated HI/LO
// product register, a direct-write path for move-to-HI/LO, and separate
// HI/LO read ports.
// Optional feature macro: MUL_SIGNED_EN (defined = honour the Signed input
// with magnitude conversion and final negation; undefined = always unsigned).
module mul_result_unit #(
  parameter int DATA_W = 24
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [DATA_W-1:0]     OperandA,
  input  logic [DATA_W-1:0]     OperandB,
  input  logic                  Signed,
  input  logic                  MulWrite,
  input  logic [2*DATA_W-1:0]   WriteMul,
  output logic                  Busy,
  output logic                  Done,
  output logic [2*DATA_W-1:0]   ReadMul,
  output logic [DATA_W-1:0]     ReadHi,
  output logic [DATA_W-1:0]     ReadLo
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_reg;
  logic [PROD_W-1:0]   product_reg;
  logic [PROD_W-1:0]   acc_reg;
  logic [PROD_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [PROD_W-1:0]   acc_next;
  logic [PROD_W-1:0]   product_next;

`ifdef MUL_SIGNED_EN
  logic                sign_reg;
  logic                sign_next;

  // Operand magnitudes and result sign for a signed request; the most-negative
  // value negates onto itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a     = (Signed && OperandA[DATA_W-1]) ? -OperandA : OperandA;
    mag_b     = (Signed && OperandB[DATA_W-1]) ? -OperandB : OperandB;
    sign_next = Signed & (OperandA[DATA_W-1] ^ OperandB[DATA_W-1]);
  end

  // Final step: the last partial add, negated when the result is negative.
  always_comb begin
    acc_next     = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    product_next = sign_reg ? -acc_next : acc_next;
  end

  // Result sign captured at Start, held for the whole run.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sign_reg <= 1'b0;
    end else if (state_reg == IDLE && Start) begin
      sign_reg <= sign_next;
    end
  end
`else
  // Signed is accepted but has no effect in the unsigned-only build.
  logic                unused_signed;
  assign unused_signed = Signed;

  // Unsigned-only build: operands are used as-is.
  always_comb begin
    mag_a = OperandA;
    mag_b = OperandB;
  end

  // Final step: the last partial add goes straight to the product register.
  always_comb begin
    acc_next     = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    product_next = acc_next;
  end
`endif

  // Control FSM plus datapath: accept Start/MulWrite in IDLE, one shift-add per RUN cycle.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_reg   <= IDLE;
      product_reg <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (Start) begin
            // Start takes priority over a simultaneous direct load.
            mcand_reg  <= {{DATA_W{1'b0}}, mag_a};
            mplier_reg <= mag_b;
            acc_reg    <= '0;
            count_reg  <= CNT_W'(DATA_W);
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else if (MulWrite) begin
            product_reg <= WriteMul;
          end
        end
        RUN: begin
          // Start and MulWrite are deliberately not looked at here.
          acc_reg    <= acc_next;
          mcand_reg  <= {mcand_reg[PROD_W-2:0], 1'b0};
          mplier_reg <= {1'b0, mplier_reg[DATA_W-1:1]};
          count_reg  <= count_reg - 1'b1;
          if (count_reg == CNT_W'(1)) begin
            product_reg <= product_next;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign ReadMul = product_reg;

  // HI/LO read ports are plain bit slices of the product register.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_hilo
    assign ReadLo[gi] = product_reg[gi];
    assign ReadHi[gi] = product_reg[DATA_W + gi];
  end

endmodule

// File: tb/tb_mul_result_unit.sv
// Directed testbench for mul_result_unit (DATA_W = 24).
// Expected values for signed operations depend on MUL_SIGNED_EN.
module tb_mul_result_unit;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic [23:0] OperandA;
  logic [23:0] OperandB;
  logic        Signed;
  logic        MulWrite;
  logic [47:0] WriteMul;
  logic        Busy;
  logic        Done;
  logic [47:0] ReadMul;
  logic [23:0] ReadHi;
  logic [23:0] ReadLo;

  int n_checks = 0;
  int n_fail   = 0;

  mul_result_unit #(.DATA_W(24)) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Start    (Start),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Signed   (Signed),
    .MulWrite (MulWrite),
    .WriteMul (WriteMul),
    .Busy     (Busy),
    .Done     (Done),
    .ReadMul  (ReadMul),
    .ReadHi   (ReadHi),
    .ReadLo   (ReadLo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Starts a multiply (caller sits 1 time unit after a rising edge) and waits,
  // bounded, for Done. Optionally drives MulWrite with Start, and optionally
  // injects Start+MulWrite with junk operands at cycle inj of the run.
  task automatic do_mul(input logic [23:0] a, input logic [23:0] b, input logic s,
                        input logic mw, input logic [47:0] wd, input int inj,
                        output int lat, output int busy_cycles, output bit held);
    logic [47:0] prev;
    prev     = ReadMul;
    OperandA = a;
    OperandB = b;
    Signed   = s;
    MulWrite = mw;
    WriteMul = wd;
    Start    = 1'b1;
    @(posedge Clock); #1;
    Start       = 1'b0;
    MulWrite    = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    held        = 1'b1;
    while (Done !== 1'b1 && lat < 100) begin
      if (Busy === 1'b1) busy_cycles++;
      if (ReadMul !== prev) held = 1'b0;
      if (inj > 0 && lat == inj) begin
        Start    = 1'b1;
        MulWrite = 1'b1;
        OperandA = 24'hFFFFFF;
        OperandB = 24'hFFFFFF;
        Signed   = 1'b1;
        WriteMul = 48'hA5A5A5A5A5A5;
      end else begin
        Start    = 1'b0;
        MulWrite = 1'b0;
      end
      @(posedge Clock); #1;
      lat++;
    end
    Start    = 1'b0;
    MulWrite = 1'b0;
    $display("mul a=%h b=%h s=%b -> ReadMul=%h latency=%0d busy=%0d", a, b, s, ReadMul, lat, busy_cycles);
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++;
    if (ReadMul !== 48'h0) begin n_fail++; $display("FAIL reset_readmul: got %h expected %h", ReadMul, 48'h0); end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_checks++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done); end
    ResetN = 1'b1;
    @(posedge Clock); #1;
    // Load something, then assert reset between edges: must clear with no clock edge.
    MulWrite = 1'b1;
    WriteMul = 48'hFEDCBA987654;
    @(posedge Clock); #1;
    MulWrite = 1'b0;
    n_checks++;
    if (ReadMul !== 48'hFEDCBA987654) begin n_fail++; $display("FAIL preload_readmul: got %h expected %h", ReadMul, 48'hFEDCBA987654); end
    #2;
    ResetN = 1'b0;
    #1;
    n_checks++;
    if (ReadMul !== 48'h0) begin n_fail++; $display("FAIL async_reset_readmul: got %h expected %h", ReadMul, 48'h0); end
    $display("reset: async clear ReadMul=%h", ReadMul);
    @(posedge Clock); #1;
    ResetN = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_unsigned();
    int lat, bc;
    bit held;
    do_mul(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (lat !== 24) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 24", lat); end
    n_checks++;
    if (bc !== 24) begin n_fail++; $display("FAIL unsigned_busy_cycles: got %0d expected 24", bc); end
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL unsigned_hold: ReadMul changed during run, expected held"); end
    n_checks++;
    if (ReadMul !== 48'hFFFFFE000001) begin n_fail++; $display("FAIL unsigned_readmul: got %h expected %h", ReadMul, 48'hFFFFFE000001); end
    n_checks++;
    if (ReadHi !== 24'hFFFFFE) begin n_fail++; $display("FAIL unsigned_readhi: got %h expected %h", ReadHi, 24'hFFFFFE); end
    n_checks++;
    if (ReadLo !== 24'h000001) begin n_fail++; $display("FAIL unsigned_readlo: got %h expected %h", ReadLo, 24'h000001); end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL unsigned_busy_at_done: got %b expected 0", Busy); end
    @(posedge Clock); #1;
    n_checks++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL unsigned_done_width: got %b expected 0", Done); end
  endtask

  task automatic test_signed();
    int lat, bc;
    bit held;
    logic [47:0] exp_neg;
`ifdef MUL_SIGNED_EN
    exp_neg = 48'hFFFFFFFFFFF1;
`else
    exp_neg = 48'h000004FFFFF1;
`endif
    do_mul(24'hFFFFFD, 24'h000005, 1'b1, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (ReadMul !== exp_neg) begin n_fail++; $display("FAIL signed_neg3x5: got %h expected %h", ReadMul, exp_neg); end
    @(posedge Clock); #1;
    do_mul(24'h800000, 24'h800000, 1'b1, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (ReadMul !== 48'h400000000000) begin n_fail++; $display("FAIL signed_minxmin: got %h expected %h", ReadMul, 48'h400000000000); end
    @(posedge Clock); #1;
    do_mul(24'hFFFFFD, 24'h000005, 1'b0, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (ReadMul !== 48'h000004FFFFF1) begin n_fail++; $display("FAIL unsigned_fffffd_x5: got %h expected %h", ReadMul, 48'h000004FFFFF1); end
`ifdef MUL_SIGNED_EN
    @(posedge Clock); #1;
    do_mul(24'hFFFFFE, 24'hFFFFFD, 1'b1, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (ReadMul !== 48'h000000000006) begin n_fail++; $display("FAIL signed_neg2xneg3: got %h expected %h", ReadMul, 48'h000000000006); end
`endif
    @(posedge Clock); #1;
  endtask

  task automatic test_ignore();
    int lat, bc, extra;
    bit held;
    do_mul(24'h000123, 24'h000456, 1'b0, 1'b0, 48'h0, 5, lat, bc, held);
    n_checks++;
    if (ReadMul !== 48'h00000004EDC2) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", ReadMul, 48'h00000004EDC2); end
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL ignore_hold: ReadMul changed during run, expected held"); end
    n_checks++;
    if (lat !== 24) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 24", lat); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock); #1;
      if (Done === 1'b1 || Busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL ignore_single_done: got %0d extra busy/done cycles expected 0", extra); end
  endtask

  task automatic test_direct_load();
    MulWrite = 1'b1;
    WriteMul = 48'h123456789ABC;
    @(posedge Clock); #1;
    MulWrite = 1'b0;
    n_checks++;
    if (ReadHi !== 24'h123456) begin n_fail++; $display("FAIL load_readhi: got %h expected %h", ReadHi, 24'h123456); end
    n_checks++;
    if (ReadLo !== 24'h789ABC) begin n_fail++; $display("FAIL load_readlo: got %h expected %h", ReadLo, 24'h789ABC); end
    n_checks++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL load_done: got %b expected 0", Done); end
    $display("load WriteMul=%h -> ReadMul=%h", 48'h123456789ABC, ReadMul);
  endtask

  task automatic test_start_wins();
    int lat, bc;
    bit held;
    do_mul(24'h000007, 24'h000006, 1'b0, 1'b1, 48'hCAFEF00DBEEF, 0, lat, bc, held);
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL startwins_hold: ReadMul changed during run, expected held"); end
    n_checks++;
    if (ReadMul !== 48'h00000000002A) begin n_fail++; $display("FAIL startwins_result: got %h expected %h", ReadMul, 48'h00000000002A); end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, dones;
    bit held;
    OperandA = 24'h000100;
    OperandB = 24'h000100;
    Signed   = 1'b0;
    Start    = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    #3;
    ResetN = 1'b0;
    #1;
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy: got %b expected 0", Busy); end
    n_checks++;
    if (ReadMul !== 48'h0) begin n_fail++; $display("FAIL midrun_reset_readmul: got %h expected %h", ReadMul, 48'h0); end
    @(posedge Clock); #1;
    ResetN = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d Done pulses expected 0", dones); end
    $display("reset mid-run: aborted, Done pulses=%0d", dones);
    do_mul(24'h000007, 24'h000006, 1'b0, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (ReadMul !== 48'h00000000002A) begin n_fail++; $display("FAIL midrun_restart_result: got %h expected %h", ReadMul, 48'h00000000002A); end
    n_checks++;
    if (lat !== 24) begin n_fail++; $display("FAIL midrun_restart_latency: got %0d expected 24", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit held;
    do_mul(24'h000002, 24'h000003, 1'b0, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (ReadMul !== 48'h000000000006) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", ReadMul, 48'h000000000006); end
    // Start is driven during the Done cycle.
    do_mul(24'h000010, 24'h000010, 1'b0, 1'b0, 48'h0, 0, lat, bc, held);
    n_checks++;
    if (lat !== 24) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 24", lat); end
    n_checks++;
    if (ReadMul !== 48'h000000000100) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", ReadMul, 48'h000000000100); end
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL b2b_hold: ReadMul changed during run, expected held"); end
    @(posedge Clock); #1;
  endtask

  initial begin
    ResetN   = 1'b0;
    Start    = 1'b0;
    OperandA = '0;
    OperandB = '0;
    Signed   = 1'b0;
    MulWrite = 1'b0;
    WriteMul = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_direct_load();
    test_start_wins();
    test_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_result_unit.md
# mul_result_unit

Parametrised multiply unit with an integrated HI/LO product register for the single-cycle CPU datapath. It replaces the plain 48-bit product latch with three capabilities:
- an iterative shift-add multiplier with a Start/Busy/Done handshake;
- a direct-write path for move-to-HI/LO instructions;
- separate HI and LO read ports.

It sits beside the register file and feeds the writeback mux.

## Interface
- DATA_W, 24, operand width; the product is 2*DATA_W bits.
- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  request a multiply; sampled at the rising edge.
- OperandA  in  DATA_W  multiplicand, sampled with Start.
- OperandB  in  DATA_W  multiplier, sampled with Start.
- Signed  in  1  1 = two's-complement multiply, 0 = unsigned; sampled with Start.
- MulWrite  in  1  direct load of the product register.
- WriteMul  in  2*DATA_W  data for the direct load.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse when a new product becomes visible.
- ReadMul  out  2*DATA_W  product register.
- ReadHi  out  DATA_W  ReadMul[2*DATA_W-1:DATA_W].
- ReadLo  out  DATA_W  ReadMul[DATA_W-1:0].

## Operation
- FSM states: IDLE and RUN.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE;
  - product register = 0;
  - accumulator and counter = 0;
  - Busy = 0, Done = 0.
- IDLE with Start=1:
  - latch the operand magnitudes (|A|, |B| when Signed is effective, raw values otherwise);
  - record the result sign as A[msb] XOR B[msb] when Signed, else 0;
  - clear the 2*DATA_W-bit accumulator;
  - counter = DATA_W;
  - go to RUN.
- RUN, each cycle:
  - if multiplier LSB = 1, accumulator += shifted multiplicand;
  - shift the multiplier right and the multiplicand left;
  - decrement the counter.
- RUN, when the counter reaches 1 (last step):
  - write the accumulator into the product register, negated (two's complement, 2*DATA_W bits) if the sign flag is set;
  - pulse Done;
  - go to IDLE.
- The accumulator is separate from the product register, so ReadMul holds the previous product for the whole of RUN.
- IDLE with MulWrite=1 and Start=0: product register = WriteMul at the next edge. No Done pulse.
- Simultaneous Start and MulWrite in IDLE: Start wins; MulWrite is dropped.
- Start or MulWrite during RUN: ignored. No queuing, and no effect on the operation in flight.
- Arithmetic:
  - the product is exact in 2*DATA_W bits; there is no overflow or saturation;
  - signed most-negative × most-negative = 2^(2*DATA_W-2), which is representable;
  - the magnitude of the most-negative operand is taken as an unsigned DATA_W-bit value.

## Timing
- Start high at edge k:
  - Busy is high during cycles k+1 … k+DATA_W;
  - the product register updates at edge k+DATA_W;
  - Done is high for exactly the one cycle after edge k+DATA_W;
  - Busy is low in that same cycle.
- Total latency from Start to Done is DATA_W cycles (24 by default).
- A new Start is accepted in the Done cycle, giving back-to-back operations every DATA_W+1 cycles minimum.
- A direct load has a latency of 1 cycle: ReadMul reflects WriteMul after the edge.
- All outputs are registered or taken directly from the product register; there are no combinational input-to-output paths.
- ResetN asserted mid-RUN:
  - Busy and Done drop immediately;
  - ReadMul = 0;
  - the partial product is discarded and no Done is produced.

## Configuration
- MUL_SIGNED_EN:
  - defined: the Signed input is honoured; magnitude conversion and final negation logic are built.
  - undefined: Signed is ignored (the port remains) and every multiply is unsigned; the sign and negation logic is not built.

## Test plan
- Reset: drive ResetN=0 mid-simulation -> ReadMul=0, Busy=0, Done=0 asynchronously, with no clock edge required.
- Unsigned, DATA_W=24: Start with A=0xFFFFFF, B=0xFFFFFF, Signed=0 -> Busy for 24 cycles, then Done pulses for 1 cycle with ReadMul=0xFFFFFE000001, ReadHi=0xFFFFFE, ReadLo=0x000001.
- Signed (macro defined), Signed=1:
  - A=0xFFFFFD (-3), B=0x000005 -> ReadMul=0xFFFFFFFFFFF1;
  - A=B=0x800000 -> ReadMul=0x400000000000;
  - with the macro undefined, A=0xFFFFFD, B=0x000005 -> ReadMul=0x000004FFFFF1.
- Ignore rules: pulse Start with new operands and MulWrite=1 at cycle 5 of a run -> the original product is unaffected, ReadMul holds its previous value until Done, and there is exactly one Done pulse.
- Direct load: in IDLE, MulWrite=1, WriteMul=0x123456789ABC -> next cycle ReadHi=0x123456, ReadLo=0x789ABC, Done=0. With Start=1 in the same cycle, the multiply result wins.
- Reset mid-run: assert ResetN low at cycle 10 of a run, release, then start 7×6 -> no Done for the aborted run, then after 24 cycles ReadMul=0x00000000002A.
